// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: launch side drives operands,
// adder side returns status and the held result.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first,
// result and signed overflow presented with a one-cycle done pulse.
//
//   state  | meaning
//   S_IDLE | waiting for start; outputs hold the last result
//   S_RUN  | one operand bit added per clock, busy high
//   S_DONE | result registers just updated, done high; start relaunches here
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cmsb_q, cout_q, ovf_q, busy_q, done_q;

  logic             sbit_d, carry_d;
  logic [WIDTH-1:0] part_d;

  always_comb begin
    sbit_d  = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    part_d  = {sbit_d, part_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          part_q  <= part_d;
          carry_q <= carry_d;
          // Carry into the MSB is the carry out of bit WIDTH-2.
          if (cnt_q == PENULT) cmsb_q <= carry_d;
          if (cnt_q == LAST) begin
            sum_q   <= part_d;
            cout_q  <= carry_d;
            ovf_q   <= cmsb_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
